// File: rtl/key_time_entry_pkg.sv
// key_time_entry_pkg
// Shared definitions for the keypad time-entry block: key codes with a
// command meaning, the entry FSM state encoding and the BCD digit limits
// that decide whether a typed digit is legal at a given cursor position.
package key_time_entry_pkg;

  // Keys that carry a command rather than a digit; D, E and F have no meaning
  localparam logic [3:0] KEY_EDIT   = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;
  localparam logic [3:0] KEY_LEFT   = 4'hC;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  // Largest legal value per position (0 = h10 ... 5 = s1)
  localparam logic [3:0] LIM_H10      = 4'd2;
  localparam logic [3:0] LIM_H1       = 4'd9;
  localparam logic [3:0] LIM_H1_AT_20 = 4'd3;
  localparam logic [3:0] LIM_M10      = 4'd5;
  localparam logic [3:0] LIM_M1       = 4'd9;
  localparam logic [3:0] LIM_S10      = 4'd5;
  localparam logic [3:0] LIM_S1       = 4'd9;

  localparam logic [2:0] POS_FIRST = 3'd0;
  localparam logic [2:0] POS_LAST  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // The hour-units limit depends on the tens digit already in the buffer,
  // so that 20..23 is the only legal range once h10 is 2.
  function automatic logic [3:0] digit_limit(input logic [2:0] pos,
                                             input logic [3:0] h10);
    logic [3:0] lim;
    case (pos)
      3'd0:    lim = LIM_H10;
      3'd1:    lim = (h10 == 4'd2) ? LIM_H1_AT_20 : LIM_H1;
      3'd2:    lim = LIM_M10;
      3'd3:    lim = LIM_M1;
      3'd4:    lim = LIM_S10;
      3'd5:    lim = LIM_S1;
      default: lim = 4'd0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/key_time_entry_press_sync.sv
// key_press_sync
// Turns the scanner's key_valid level (asynchronous to clk) into a single
// debounced one-cycle press event with the matching key code.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   key_valid, key_code : raw scanner level and code
//   press               : one-cycle pulse per accepted key press
//   code                : key code captured with the press, held until the next
module key_press_sync #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       press,
  output logic [3:0] code
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic          valid_meta;
  logic          valid_sync;
  logic [3:0]    code_meta;
  logic [3:0]    code_sync;
  logic          level;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] cnt_next;
  logic          armed;
  logic          settled;

  // Two-flop synchronizers for the level and every code bit
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_meta <= 1'b0;
      valid_sync <= 1'b0;
      code_meta  <= 4'd0;
      code_sync  <= 4'd0;
    end else begin
      valid_meta <= key_valid;
      valid_sync <= valid_meta;
      code_meta  <= key_code;
      code_sync  <= code_meta;
    end
  end

  // A change of the synced level restarts the count at one, since the cycle
  // of the change is itself the first cycle at the new level.
  always_comb begin
    if (valid_sync != level)
      cnt_next = CW'(1);
    else if (stable_cnt == CNT_MAX)
      cnt_next = CNT_MAX;
    else
      cnt_next = stable_cnt + CW'(1);
  end

  assign settled = (cnt_next == CNT_MAX);

  // Press fires once when a high level settles while armed; only a settled
  // low level re-arms, so holding a key never repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      level      <= 1'b0;
      stable_cnt <= '0;
      armed      <= 1'b0;
      press      <= 1'b0;
      code       <= 4'd0;
    end else begin
      level      <= valid_sync;
      stable_cnt <= cnt_next;
      press      <= 1'b0;
      if (settled && valid_sync && armed) begin
        press <= 1'b1;
        armed <= 1'b0;
        code  <= code_sync;
      end else if (settled && !valid_sync) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_time_entry.sv
// key_time_entry
// Keypad-driven HH:MM:SS time entry. A debounced press of A opens an edit
// session on a copy of the live time; digits overwrite the BCD buffer at the
// cursor with range checking, C moves the cursor left, B abandons the edit
// and A commits it to set_time with a one-cycle strobe. An idle edit session
// is abandoned after TIMEOUT_CYCLES.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   key_valid, key_code : raw scanner level and code
//   cur_time            : live BCD time, copied into the buffer on edit entry
//   set_time/set_strobe : committed time and its one-cycle update pulse
//   editing, cursor     : edit session flag and position (0 = h10 .. 5 = s1)
//   edit_buf            : working BCD buffer for the display
//   digit_err           : one-cycle pulse when a digit is out of range
module key_time_entry
  import key_time_entry_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        set_strobe,
  output logic        editing,
  output logic [2:0]  cursor,
  output logic [23:0] edit_buf,
  output logic        digit_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          press;
  logic [3:0]    code;

  state_t        state, state_nxt;
  logic [2:0]    pos, pos_nxt;
  logic [23:0]   buf_nxt;
  logic [23:0]   set_time_nxt;
  logic          strobe_nxt;
  logic          err_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;

  key_press_sync #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_press_sync (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .press     (press),
    .code      (code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pos        <= POS_FIRST;
      edit_buf   <= 24'd0;
      set_time   <= 24'd0;
      set_strobe <= 1'b0;
      digit_err  <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      edit_buf   <= buf_nxt;
      set_time   <= set_time_nxt;
      set_strobe <= strobe_nxt;
      digit_err  <= err_nxt;
      tmo_cnt    <= tmo_nxt;
    end
  end

  // Inside EDIT a press always takes priority over the timeout, and any
  // press (even an ignored key) restarts the idle count.
  always_comb begin
    state_nxt    = state;
    pos_nxt      = pos;
    buf_nxt      = edit_buf;
    set_time_nxt = set_time;
    strobe_nxt   = 1'b0;
    err_nxt      = 1'b0;
    tmo_nxt      = tmo_cnt;
    case (state)
      ST_IDLE: begin
        if (press && code == KEY_EDIT) begin
          state_nxt = ST_EDIT;
          buf_nxt   = cur_time;
          pos_nxt   = POS_FIRST;
          tmo_nxt   = '0;
        end
      end
      ST_EDIT: begin
        if (press) begin
          tmo_nxt = '0;
          if (code <= KEY_MAX_DIGIT) begin
            if (code <= digit_limit(pos, edit_buf[23:20])) begin
              for (int i = 0; i < 6; i++) begin
                if (pos == 3'(i))
                  buf_nxt[20-4*i +: 4] = code;
              end
              // Entering 2x hours would make an existing 24..29 illegal
              if (pos == POS_FIRST && code == 4'd2 && edit_buf[19:16] > LIM_H1_AT_20)
                buf_nxt[19:16] = 4'd0;
              if (pos != POS_LAST)
                pos_nxt = pos + 3'd1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (code == KEY_LEFT) begin
            if (pos != POS_FIRST)
              pos_nxt = pos - 3'd1;
          end else if (code == KEY_CANCEL) begin
            state_nxt = ST_IDLE;
            pos_nxt   = POS_FIRST;
          end else if (code == KEY_EDIT) begin
            state_nxt = ST_COMMIT;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_IDLE;
          pos_nxt   = POS_FIRST;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      ST_COMMIT: begin
        set_time_nxt = edit_buf;
        strobe_nxt   = 1'b1;
        pos_nxt      = POS_FIRST;
        state_nxt    = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        pos_nxt   = POS_FIRST;
      end
    endcase
  end

  assign editing = (state == ST_EDIT);
  assign cursor  = editing ? pos : 3'd0;

endmodule

// File: tb/tb_key_time_entry.sv
// tb_key_time_entry
// Directed bench for key_time_entry with a short timeout (100 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_key_time_entry;
  import key_time_entry_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [23:0] cur_time = 24'd0;
  logic [23:0] set_time;
  logic        set_strobe;
  logic        editing;
  logic [2:0]  cursor;
  logic [23:0] edit_buf;
  logic        digit_err;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int edit_rises = 0;
  logic editing_q = 1'b0;

  key_time_entry #(
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .cur_time(cur_time), .set_time(set_time), .set_strobe(set_strobe),
    .editing(editing), .cursor(cursor), .edit_buf(edit_buf), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  // Pulse counters so single-cycle events are never missed
  always @(negedge clk) begin
    if (set_strobe) strobe_cnt++;
    if (digit_err) err_cnt++;
    if (editing && !editing_q) edit_rises++;
    editing_q = editing;
  end

  task automatic press_key(input logic [3:0] k);
    @(negedge clk);
    key_code = k;
    key_valid = 1'b1;
    repeat (20) @(negedge clk);
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (set_time !== 24'd0) begin errors++; $display("[TB] FAIL reset_set_time got %h want 000000", set_time); end
    checks++; if (set_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe got %b want 0", set_strobe); end
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL reset_editing got %b want 0", editing); end
    checks++; if (cursor !== 3'd0) begin errors++; $display("[TB] FAIL reset_cursor got %0d want 0", cursor); end
    checks++; if (edit_buf !== 24'd0) begin errors++; $display("[TB] FAIL reset_edit_buf got %h want 000000", edit_buf); end
    checks++; if (digit_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_digit_err got %b want 0", digit_err); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic_entry;
    logic [3:0]  keys [6];
    logic [23:0] exp_buf [6];
    logic [2:0]  exp_cur [6];
    int s0;
    keys    = '{4'h1, 4'h9, 4'h4, 4'h5, 4'h0, 4'h7};
    exp_buf = '{24'h123456, 24'h193456, 24'h194456, 24'h194556, 24'h194506, 24'h194507};
    exp_cur = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    s0 = strobe_cnt;
    cur_time = 24'h123456;
    press_key(KEY_EDIT);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL basic_enter editing got %b want 1", editing); end
    checks++; if (edit_buf !== 24'h123456) begin errors++; $display("[TB] FAIL basic_load got %h want 123456", edit_buf); end
    for (int i = 0; i < 6; i++) begin
      press_key(keys[i]);
      checks++; if (edit_buf !== exp_buf[i]) begin errors++; $display("[TB] FAIL basic_buf[%0d] got %h want %h", i, edit_buf, exp_buf[i]); end
      checks++; if (cursor !== exp_cur[i]) begin errors++; $display("[TB] FAIL basic_cursor[%0d] got %0d want %0d", i, cursor, exp_cur[i]); end
    end
    press_key(KEY_EDIT);
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("[TB] FAIL basic_strobes got %0d want 1", strobe_cnt - s0); end
    checks++; if (set_time !== 24'h194507) begin errors++; $display("[TB] FAIL basic_set_time got %h want 194507", set_time); end
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL basic_exit editing got %b want 0", editing); end
    checks++; if (cursor !== 3'd0) begin errors++; $display("[TB] FAIL basic_exit cursor got %0d want 0", cursor); end
  endtask

  task automatic test_limits_and_cancel;
    logic [3:0]  keys [6];
    logic [23:0] exp_buf [6];
    logic [2:0]  exp_cur [6];
    int          exp_err [6];
    int e0, s0;
    keys    = '{4'h3, 4'h2, 4'h4, 4'h3, 4'h6, 4'h5};
    exp_buf = '{24'h071234, 24'h201234, 24'h201234, 24'h231234, 24'h231234, 24'h235234};
    exp_cur = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
    exp_err = '{1, 0, 1, 0, 1, 0};
    s0 = strobe_cnt;
    cur_time = 24'h071234;
    press_key(KEY_EDIT);
    for (int i = 0; i < 6; i++) begin
      e0 = err_cnt;
      press_key(keys[i]);
      checks++; if (edit_buf !== exp_buf[i]) begin errors++; $display("[TB] FAIL limit_buf[%0d] got %h want %h", i, edit_buf, exp_buf[i]); end
      checks++; if (cursor !== exp_cur[i]) begin errors++; $display("[TB] FAIL limit_cursor[%0d] got %0d want %0d", i, cursor, exp_cur[i]); end
      checks++; if (err_cnt - e0 !== exp_err[i]) begin errors++; $display("[TB] FAIL limit_err[%0d] got %0d want %0d", i, err_cnt - e0, exp_err[i]); end
    end
    press_key(KEY_CANCEL);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL cancel_editing got %b want 0", editing); end
    checks++; if (set_time !== 24'h194507) begin errors++; $display("[TB] FAIL cancel_set_time got %h want 194507", set_time); end
    checks++; if (strobe_cnt !== s0) begin errors++; $display("[TB] FAIL cancel_strobes got %0d want %0d", strobe_cnt, s0); end
  endtask

  task automatic test_cursor;
    logic [2:0] exp_cur [7];
    int s0;
    exp_cur = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    s0 = strobe_cnt;
    cur_time = 24'h000000;
    press_key(KEY_EDIT);
    for (int i = 1; i <= 6; i++) press_key(4'(i));
    press_key(4'h8);
    checks++; if (edit_buf !== 24'h123458) begin errors++; $display("[TB] FAIL sat_buf got %h want 123458", edit_buf); end
    checks++; if (cursor !== 3'd5) begin errors++; $display("[TB] FAIL sat_cursor got %0d want 5", cursor); end
    for (int i = 0; i < 7; i++) begin
      press_key(KEY_LEFT);
      checks++; if (cursor !== exp_cur[i]) begin errors++; $display("[TB] FAIL left_cursor[%0d] got %0d want %0d", i, cursor, exp_cur[i]); end
    end
    press_key(KEY_EDIT);
    checks++; if (set_time !== 24'h123458) begin errors++; $display("[TB] FAIL sat_set_time got %h want 123458", set_time); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("[TB] FAIL sat_strobes got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_ignored_keys;
    logic [3:0] keys [6];
    int s0, e0, r0;
    keys = '{4'hD, 4'hE, 4'hF, 4'h5, KEY_LEFT, KEY_CANCEL};
    s0 = strobe_cnt; e0 = err_cnt; r0 = edit_rises;
    for (int i = 0; i < 6; i++) press_key(keys[i]);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL idle_editing got %b want 0", editing); end
    checks++; if (edit_buf !== 24'h123458) begin errors++; $display("[TB] FAIL idle_edit_buf got %h want 123458", edit_buf); end
    checks++; if (set_time !== 24'h123458) begin errors++; $display("[TB] FAIL idle_set_time got %h want 123458", set_time); end
    checks++; if (strobe_cnt !== s0 || err_cnt !== e0 || edit_rises !== r0) begin
      errors++; $display("[TB] FAIL idle_events strobe %0d err %0d rises %0d want 0 0 0", strobe_cnt - s0, err_cnt - e0, edit_rises - r0);
    end
    cur_time = 24'h010203;
    press_key(KEY_EDIT);
    press_key(4'hD);
    press_key(4'hE);
    press_key(4'hF);
    checks++; if (edit_buf !== 24'h010203) begin errors++; $display("[TB] FAIL def_edit_buf got %h want 010203", edit_buf); end
    checks++; if (cursor !== 3'd0 || editing !== 1'b1) begin errors++; $display("[TB] FAIL def_state cursor %0d editing %b want 0 1", cursor, editing); end
    checks++; if (err_cnt !== e0) begin errors++; $display("[TB] FAIL def_err got %0d want 0", err_cnt - e0); end
    press_key(KEY_CANCEL);
  endtask

  task automatic test_timeout;
    logic found;
    int s0;
    s0 = strobe_cnt;
    // Idle until timeout: EDIT lasts exactly 100 cycles
    @(negedge clk);
    key_code = KEY_EDIT;
    key_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (editing) found = 1'b1;
    end
    key_valid = 1'b0;
    checks++; if (!found) begin errors++; $display("[TB] FAIL tmo_enter editing got 0 want 1 within 50 cycles"); end
    repeat (99) @(negedge clk);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL tmo_before got %b want 1", editing); end
    @(negedge clk);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL tmo_expire got %b want 0", editing); end
    repeat (20) @(negedge clk);
    // A press that lands on the final idle cycle wins and restarts the count
    @(negedge clk);
    key_code = KEY_EDIT;
    key_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (editing) found = 1'b1;
    end
    key_valid = 1'b0;
    checks++; if (!found) begin errors++; $display("[TB] FAIL tmo2_enter editing got 0 want 1 within 50 cycles"); end
    repeat (93) @(negedge clk);
    key_code = KEY_LEFT;
    key_valid = 1'b1;
    repeat (7) @(negedge clk);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL tmo_press_wins got %b want 1", editing); end
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (96) @(negedge clk);
    checks++; if (editing !== 1'b1) begin errors++; $display("[TB] FAIL tmo_restart_before got %b want 1", editing); end
    @(negedge clk);
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL tmo_restart_expire got %b want 0", editing); end
    checks++; if (strobe_cnt !== s0) begin errors++; $display("[TB] FAIL tmo_strobes got %0d want 0", strobe_cnt - s0); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_debounce;
    int r0;
    r0 = edit_rises;
    @(negedge clk);
    key_code = KEY_EDIT;
    key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (edit_rises !== r0 || editing !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch rises %0d editing %b want 0 0", edit_rises - r0, editing);
    end
    key_valid = 1'b1;
    repeat (10000) @(negedge clk);
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (edit_rises - r0 !== 1) begin errors++; $display("[TB] FAIL hold_events got %0d want 1", edit_rises - r0); end
    checks++; if (editing !== 1'b0) begin errors++; $display("[TB] FAIL hold_final editing got %b want 0", editing); end
  endtask

  task automatic test_reset_mid_edit;
    int s0;
    s0 = strobe_cnt;
    cur_time = 24'h111111;
    press_key(KEY_EDIT);
    press_key(4'h2);
    checks++; if (edit_buf !== 24'h211111 || cursor !== 3'd1) begin
      errors++; $display("[TB] FAIL pre_reset buf %h cursor %0d want 211111 1", edit_buf, cursor);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (editing !== 1'b0 || cursor !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset editing %b cursor %0d want 0 0", editing, cursor); end
    checks++; if (edit_buf !== 24'd0) begin errors++; $display("[TB] FAIL mid_reset edit_buf got %h want 000000", edit_buf); end
    checks++; if (set_time !== 24'd0) begin errors++; $display("[TB] FAIL mid_reset set_time got %h want 000000", set_time); end
    checks++; if (set_strobe !== 1'b0 || digit_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset pulses strobe %b err %b want 0 0", set_strobe, digit_err); end
    repeat (10) @(negedge clk);
    checks++; if (strobe_cnt !== s0) begin errors++; $display("[TB] FAIL mid_reset strobes got %0d want 0", strobe_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_limits_and_cancel();
    test_cursor();
    test_ignored_keys();
    test_timeout();
    test_debounce();
    test_reset_mid_edit();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_time_entry.md
# key_time_entry

Converts raw matrix-keypad output (`key_valid` level plus `key_code`) into a debounced single press event. Runs a digit-entry state machine that lets the user type a new HH:MM:SS time in BCD. Sits directly downstream of the matrix keyboard scanner and upstream of the clock counter's load port and the display mux, which shows `edit_buf` and `cursor` while editing.

## Interface
- `STABLE_CYCLES`, default 4: consecutive `clk` cycles the synchronized `key_valid` must hold before a press (or release) is accepted.
- `TIMEOUT_CYCLES`, default 500_000_000: idle cycles in EDIT before automatic cancel; 10 s at 50 MHz.
- `clk`, in, 1: 50 MHz system clock; the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `key_valid`, in, 1: scanner key-held level; asynchronous to `clk` because it is produced on the scanner's divided clock.
- `key_code`, in, 4: scanner key value; only meaningful while `key_valid` is high.
- `cur_time`, in, 24: live BCD time {h10,h1,m10,m1,s10,s1}, 4 bits per digit; preloaded on edit entry.
- `set_time`, out, 24: committed BCD time; held until the next commit.
- `set_strobe`, out, 1: one-cycle pulse when `set_time` is updated.
- `editing`, out, 1: high while in EDIT.
- `cursor`, out, 3: edit position; 0 = h10 through 5 = s1.
- `edit_buf`, out, 24: working BCD buffer for display.
- `digit_err`, out, 1: one-cycle pulse when a digit is rejected.

## Operation
- Front end:
  - Two-flop synchronizer on `key_valid` and on each `key_code` bit.
  - A stability counter counts consecutive cycles in which the synced `key_valid` is unchanged.
  - On reaching `STABLE_CYCLES` with level 1 while disarmed-released, capture the synced `key_code` and emit an internal one-cycle `press`.
  - Re-arm only after level 0 has been stable for `STABLE_CYCLES`.
  - A held key yields exactly one `press`; no auto-repeat.
- Key map: 0–9 are digits; A = edit/commit; B = cancel; C = cursor left; D, E, F are ignored in every state.
- FSM states IDLE, EDIT and COMMIT:
  - **IDLE:**
    - `press` with A loads `edit_buf` ← `cur_time`, sets `cursor` ← 0, clears the timeout counter, and goes to EDIT.
    - All other keys are ignored.
  - **EDIT, digit `d` at position `p`:**
    - Limits: p0 ≤ 2; p1 ≤ 9, or ≤ 3 if h10 = 2; p2 ≤ 5; p3 ≤ 9; p4 ≤ 5; p5 ≤ 9.
    - Valid digit: write `edit_buf[p]` ← `d`, then `cursor` ← min(p+1, 5). At p5 the cursor saturates and further digits overwrite s1.
    - Writing h10 = 2 while h1 > 3 also forces h1 ← 0.
    - Invalid digit: buffer and cursor unchanged, `digit_err` pulses.
  - **EDIT, other keys:**
    - C: `cursor` ← max(p−1, 0).
    - B: return to IDLE, discarding `edit_buf`; no strobe.
    - A: go to COMMIT.
  - **EDIT, timeout:**
    - Any `press` clears the timeout counter.
    - When the counter reaches `TIMEOUT_CYCLES − 1` with no press, return to IDLE as if cancelled.
    - If a press and the timeout coincide, the press wins.
  - **COMMIT:** `set_time` ← `edit_buf`, `set_strobe` = 1 for this cycle only, `cursor` ← 0, next state IDLE.
- Outside EDIT, `edit_buf` holds its last value and `cursor` reads 0.

## Timing
- Reset values: `set_time` = 0 (00:00:00), `set_strobe` = 0, `editing` = 0, `cursor` = 0, `edit_buf` = 0, `digit_err` = 0, FSM in IDLE, front end disarmed with level 0 assumed.
- Press latency:
  - `key_valid` first sampled high at edge 0.
  - Synced level is high after edge 1.
  - `press` is registered high after edge 1+`STABLE_CYCLES` (edge 5 by default) for one cycle.
  - FSM outputs (`editing`, `edit_buf`, `cursor`, `digit_err`) update after the following edge (edge 6).
- Commit: A press handled at edge N puts the FSM in COMMIT after N; `set_time` and `set_strobe` are registered after edge N+1; `set_strobe` is low again after N+2.
- Glitches: a `key_valid` glitch shorter than `STABLE_CYCLES` synced cycles produces no press.
- Reset mid-edit: IDLE on the next edge, buffer discarded, no strobe, `set_time` cleared to 0.
- Arithmetic: the timeout counter is `$clog2(TIMEOUT_CYCLES)` bits and the stability counter is `$clog2(STABLE_CYCLES+1)` bits; both saturate and never wrap.

## Structure
- Shared package: key-code constants (KEY_EDIT = 4'hA, KEY_CANCEL = 4'hB, KEY_LEFT = 4'hC), FSM state encoding, BCD digit-limit constants.
- One sub-module, `key_press_sync`: synchronizer, stability counter and press/re-arm logic, outputting `press` and `code`. `key_time_entry` instantiates it and holds the FSM and buffer.

## Test plan
- **Basic entry:** `cur_time` = 12:34:56; press A, 1, 9, 4, 5, 0, 7, A (each held 20 cycles, gaps 20 cycles) → `set_strobe` pulses once, `set_time` = 24'h194507, `editing` falls.
- **Limit checks:** in EDIT, press 3 at p0 → `digit_err` pulse, buffer unchanged. Press 2 at p0 with h1 = 7 → h10 = 2, h1 = 0, `cursor` = 1. Then press 4 → rejected.
- **Cursor saturation:** six valid digits then 8 → s1 = 8 and `cursor` stays 5. C ×7 from 5 → `cursor` = 0.
- **Cancel and timeout:**
  - Press B mid-edit → `editing` = 0, `set_time` unchanged, no strobe.
  - With `TIMEOUT_CYCLES` = 100, entering EDIT and idling → `editing` falls after 100 cycles.
  - A press at cycle 99 keeps EDIT.
- **Debounce and hold:**
  - A `key_valid` pulse of 3 cycles → no event.
  - A key held 10 000 cycles → exactly one event.
  - Keys D/E/F and digits pressed in IDLE → no output change.
- **Reset:** assert `reset` one cycle while in EDIT with a modified buffer → all outputs at reset values next cycle, no strobe.
